ddr3_init_seq: RTL

DDR3 power-up initialisation sequencer that drives the control-path half of the DFI master port until the memory is ready for traffic. It sits upstream of the DFI boundary, beside the command scheduler; a downstream mux gives DFI control to the scheduler once `init_done` rises. It first handshakes PHY readiness, then walks the JEDEC reset, CKE, MRS and ZQCL sequence using programmable cycle counts.

---
 rtl/ddr3_init_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ddr3_init_seq.sv
// rtl/ddr3_init_seq.sv - DDR3 power-up init sequencer driving the DFI control path until init_done.
// Optional ZQCL calibration step is enabled by defining DDR3_INIT_ZQCL_EN.
module ddr3_init_seq #(
    parameter int unsigned C_ROW_WIDTH  = 16,
    parameter int unsigned C_BANK_WIDTH = 3,
    parameter int unsigned T_RESET      = 40000,
    parameter int unsigned T_CKE        = 100000,
    parameter int unsigned T_XPR        = 72,
    parameter int unsigned T_MRD        = 4,
    parameter int unsigned T_MOD        = 12,
    parameter int unsigned T_ZQINIT     = 512,
    parameter logic [15:0] MR0          = 16'h0000,
    parameter logic [15:0] MR1          = 16'h0000,
    parameter logic [15:0] MR2          = 16'h0000,
    parameter logic [15:0] MR3          = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    dfi_init_start,
    input  logic                    dfi_init_complete,
    output logic                    dfi_reset_n,
    output logic                    dfi_cke,
    output logic                    dfi_cs_n,
    output logic                    dfi_ras_n,
    output logic                    dfi_cas_n,
    output logic                    dfi_we_n,
    output logic [C_ROW_WIDTH-1:0]  dfi_address,
    output logic [C_BANK_WIDTH-1:0] dfi_bank,
    output logic                    dfi_odt,
    output logic                    init_done
);

    typedef enum logic [3:0] {
        S_INIT, S_PHY_WAIT, S_RST_HOLD, S_CKE_WAIT, S_XPR,
        S_MRS2, S_MRS3, S_MRS1, S_MRS0, S_ZQCL, S_DONE
    } state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [C_ROW_WIDTH+15:0] MR0_EXT = {{C_ROW_WIDTH{1'b0}}, MR0};
    localparam logic [C_ROW_WIDTH+15:0] MR1_EXT = {{C_ROW_WIDTH{1'b0}}, MR1};
    localparam logic [C_ROW_WIDTH+15:0] MR2_EXT = {{C_ROW_WIDTH{1'b0}}, MR2};
    localparam logic [C_ROW_WIDTH+15:0] MR3_EXT = {{C_ROW_WIDTH{1'b0}}, MR3};
    localparam logic [C_ROW_WIDTH-1:0]  MR0_ADDR = MR0_EXT[C_ROW_WIDTH-1:0];
    localparam logic [C_ROW_WIDTH-1:0]  MR1_ADDR = MR1_EXT[C_ROW_WIDTH-1:0];
    localparam logic [C_ROW_WIDTH-1:0]  MR2_ADDR = MR2_EXT[C_ROW_WIDTH-1:0];
    localparam logic [C_ROW_WIDTH-1:0]  MR3_ADDR = MR3_EXT[C_ROW_WIDTH-1:0];
`ifdef DDR3_INIT_ZQCL_EN
    localparam logic [3:0]              CMD_ZQCL = 4'b0110;
    localparam logic [C_ROW_WIDTH+15:0] ZQ_EXT   = {{C_ROW_WIDTH{1'b0}}, 16'h0400};
    localparam logic [C_ROW_WIDTH-1:0]  ZQ_ADDR  = ZQ_EXT[C_ROW_WIDTH-1:0];
`endif

    // A state lasting T cycles loads T-1; a zero parameter still gives one cycle.
    function automatic logic [31:0] ld(input int unsigned t);
        return (t == 0) ? 32'd0 : t - 32'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    init_start_q, init_start_d;
    logic                    reset_n_q, reset_n_d;
    logic                    cke_q, cke_d;
    logic [3:0]              cmd_q, cmd_d;
    logic [C_ROW_WIDTH-1:0]  addr_q, addr_d;
    logic [C_BANK_WIDTH-1:0] bank_q, bank_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != 32'd0) ? cnt_q - 32'd1 : 32'd0;
        init_start_d = init_start_q;
        reset_n_d    = reset_n_q;
        cke_d        = cke_q;
        cmd_d        = cke_q ? CMD_NOP : CMD_DESEL;
        addr_d       = '0;
        bank_d       = '0;
        done_d       = done_q;
        case (state_q)
            S_INIT: begin
                state_d      = S_PHY_WAIT;
                init_start_d = 1'b1;
            end
            S_PHY_WAIT: if (dfi_init_complete) begin
                state_d      = S_RST_HOLD;
                init_start_d = 1'b0;
                cnt_d        = ld(T_RESET);
            end
            S_RST_HOLD: if (cnt_q == 32'd0) begin
                state_d   = S_CKE_WAIT;
                reset_n_d = 1'b1;
                cnt_d     = ld(T_CKE);
            end
            S_CKE_WAIT: if (cnt_q == 32'd0) begin
                state_d = S_XPR;
                cke_d   = 1'b1;
                cmd_d   = CMD_NOP;
                cnt_d   = ld(T_XPR);
            end
            // Each MRS state issues its command on entry, then NOPs out the remaining gap.
            S_XPR: if (cnt_q == 32'd0) begin
                state_d = S_MRS2;
                cmd_d   = CMD_MRS;
                bank_d  = C_BANK_WIDTH'(2);
                addr_d  = MR2_ADDR;
                cnt_d   = ld(T_MRD);
            end
            S_MRS2: if (cnt_q == 32'd0) begin
                state_d = S_MRS3;
                cmd_d   = CMD_MRS;
                bank_d  = C_BANK_WIDTH'(3);
                addr_d  = MR3_ADDR;
                cnt_d   = ld(T_MRD);
            end
            S_MRS3: if (cnt_q == 32'd0) begin
                state_d = S_MRS1;
                cmd_d   = CMD_MRS;
                bank_d  = C_BANK_WIDTH'(1);
                addr_d  = MR1_ADDR;
                cnt_d   = ld(T_MRD);
            end
            S_MRS1: if (cnt_q == 32'd0) begin
                state_d = S_MRS0;
                cmd_d   = CMD_MRS;
                bank_d  = '0;
                addr_d  = MR0_ADDR;
                cnt_d   = ld(T_MOD);
            end
`ifdef DDR3_INIT_ZQCL_EN
            S_MRS0: if (cnt_q == 32'd0) begin
                state_d = S_ZQCL;
                cmd_d   = CMD_ZQCL;
                addr_d  = ZQ_ADDR;
                cnt_d   = ld(T_ZQINIT);
            end
            S_ZQCL: if (cnt_q == 32'd0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`else
            S_MRS0: if (cnt_q == 32'd0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`endif
            S_DONE: state_d = S_DONE;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_INIT;
            cnt_q        <= 32'd0;
            init_start_q <= 1'b0;
            reset_n_q    <= 1'b0;
            cke_q        <= 1'b0;
            cmd_q        <= CMD_DESEL;
            addr_q       <= '0;
            bank_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_start_q <= init_start_d;
            reset_n_q    <= reset_n_d;
            cke_q        <= cke_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            bank_q       <= bank_d;
            done_q       <= done_d;
        end
    end

    assign dfi_init_start = init_start_q;
    assign dfi_reset_n    = reset_n_q;
    assign dfi_cke        = cke_q;
    assign dfi_cs_n       = cmd_q[3];
    assign dfi_ras_n      = cmd_q[2];
    assign dfi_cas_n      = cmd_q[1];
    assign dfi_we_n       = cmd_q[0];
    assign dfi_address    = addr_q;
    assign dfi_bank       = bank_q;
    assign dfi_odt        = 1'b0;
    assign init_done      = done_q;

endmodule
